wb_stage: RTL and testbench

- Write-back stage register between the memory stage and the register file.
- Captures retiring instructions from MEM and holds loads until the data-bus acknowledge arrives.
- Aligns and sign- or zero-extends load data.
- Drives the register file write port (we/waddr/wdata) with a single-cycle write pulse per instruction, and raises a stall request to the pipeline controller while a load is outstanding.

---
 rtl/wb_stage.sv | 143 ++++++++++++++
 tb/tb_wb_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: load hold, alignment, regfile write pulse
// Optional trace port enabled by defining WB_TRACE_EN.
module wb_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        mem_valid_i,
    input  logic        mem_wd_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_load_i,
    input  logic [2:0]  mem_load_type_i,
    input  logic [1:0]  mem_addr_lo_i,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
`ifdef WB_TRACE_EN
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
`endif
    output logic        wb_we_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic [31:0] wb_pc_o,
    output logic        stallreq_o,
    output logic        bus_err_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    // Timeout fires on the edge that would end the ACK_TIMEOUT-th WAIT cycle.
    localparam logic [7:0] LIMIT = 8'(ACK_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        capture, timeout;
    logic        l_wd;
    logic [4:0]  l_waddr;
    logic [31:0] l_pc;
    logic [2:0]  l_type;
    logic [1:0]  l_lo;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] aligned;

    always_comb begin
        b = 8'(dbus_rdata_i >> {l_lo, 3'b000});
        h = l_lo[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        case (l_type)
            3'd0:    aligned = {{24{b[7]}}, b};
            3'd1:    aligned = {24'd0, b};
            3'd2:    aligned = {{16{h[15]}}, h};
            3'd3:    aligned = {16'd0, h};
            default: aligned = dbus_rdata_i;
        endcase
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                capture = mem_valid_i && !stall_i && !flush_i;
                if (capture && mem_load_i)
                    state_nxt = WAIT;
            end
            WAIT: begin
                timeout = (cnt == LIMIT);
                if (flush_i || dbus_ack_i || timeout)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stallreq_o = (state == WAIT) && !dbus_ack_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            l_wd       <= 1'b0;
            l_waddr    <= 5'd0;
            l_pc       <= 32'd0;
            l_type     <= 3'd0;
            l_lo       <= 2'd0;
            wb_we_o    <= 1'b0;
            wb_waddr_o <= 5'd0;
            wb_wdata_o <= 32'd0;
            wb_pc_o    <= 32'd0;
            bus_err_o  <= 1'b0;
        end else begin
            state     <= state_nxt;
            wb_we_o   <= 1'b0;
            bus_err_o <= 1'b0;
            if (state == IDLE) begin
                if (capture && mem_load_i) begin
                    l_wd    <= mem_wd_i;
                    l_waddr <= mem_waddr_i;
                    l_pc    <= mem_pc_i;
                    l_type  <= mem_load_type_i;
                    l_lo    <= mem_addr_lo_i;
                    cnt     <= 8'd0;
                end else if (capture) begin
                    wb_we_o    <= mem_wd_i;
                    wb_waddr_o <= mem_waddr_i;
                    wb_wdata_o <= mem_wdata_i;
                    wb_pc_o    <= mem_pc_i;
                end
            end else begin
                // Priority: flush, then ack, then timeout.
                if (flush_i) begin
                    cnt <= 8'd0;
                end else if (dbus_ack_i) begin
                    cnt        <= 8'd0;
                    wb_we_o    <= l_wd;
                    wb_waddr_o <= l_waddr;
                    wb_wdata_o <= aligned;
                    wb_pc_o    <= l_pc;
                end else if (timeout) begin
                    cnt       <= 8'd0;
                    bus_err_o <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = wb_pc_o;
    assign debug_wb_rf_wen   = {4{wb_we_o && (wb_waddr_o != 5'd0)}};
    assign debug_wb_rf_wnum  = wb_waddr_o;
    assign debug_wb_rf_wdata = wb_wdata_o;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, mem_valid_i, mem_wd_i, mem_load_i, dbus_ack_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i, mem_pc_i, dbus_rdata_i;
    logic [2:0]  mem_load_type_i;
    logic [1:0]  mem_addr_lo_i;
    logic        wb_we_o, stallreq_o, bus_err_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o, wb_pc_o;
`ifdef WB_TRACE_EN
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .mem_valid_i(mem_valid_i), .mem_wd_i(mem_wd_i), .mem_waddr_i(mem_waddr_i),
        .mem_wdata_i(mem_wdata_i), .mem_pc_i(mem_pc_i), .mem_load_i(mem_load_i),
        .mem_load_type_i(mem_load_type_i), .mem_addr_lo_i(mem_addr_lo_i),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
`ifdef WB_TRACE_EN
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
`endif
        .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
        .wb_pc_o(wb_pc_o), .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i = 0; flush_i = 0; mem_valid_i = 0; mem_wd_i = 0; mem_load_i = 0;
        dbus_ack_i = 0; mem_waddr_i = 0; mem_wdata_i = 0; mem_pc_i = 0;
        dbus_rdata_i = 0; mem_load_type_i = 0; mem_addr_lo_i = 0;
    endtask

    task automatic present(input logic wd, input logic [4:0] wa, input logic [31:0] wdat,
                           input logic [31:0] pc, input logic ld, input logic [2:0] lt,
                           input logic [1:0] lo);
        mem_valid_i = 1; mem_wd_i = wd; mem_waddr_i = wa; mem_wdata_i = wdat;
        mem_pc_i = pc; mem_load_i = ld; mem_load_type_i = lt; mem_addr_lo_i = lo;
    endtask

    task automatic write_op(input string tag, input logic [4:0] wa, input logic [31:0] wdat,
                            input logic [31:0] pc);
        present(1, wa, wdat, pc, 0, 0, 0);
        tick();
        mem_valid_i = 0;
        check({tag, "_we"}, 32'(wb_we_o), 32'd1);
        check({tag, "_waddr"}, 32'(wb_waddr_o), 32'(wa));
        check({tag, "_wdata"}, wb_wdata_o, wdat);
        check({tag, "_pc"}, wb_pc_o, pc);
`ifdef WB_TRACE_EN
        check({tag, "_dbg_wen"}, 32'(debug_wb_rf_wen), (wa != 0) ? 32'hF : 32'h0);
        check({tag, "_dbg_wdata"}, debug_wb_rf_wdata, wdat);
        check({tag, "_dbg_wnum"}, 32'(debug_wb_rf_wnum), 32'(wa));
        check({tag, "_dbg_pc"}, debug_wb_pc, pc);
`endif
        tick();
        check({tag, "_we_pulse"}, 32'(wb_we_o), 32'd0);
    endtask

    // Load acknowledged after `waits` WAIT cycles without ack.
    task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] lo,
                           input logic [31:0] rd, input int waits, input logic [4:0] wa,
                           input logic [31:0] pc, input logic [31:0] exp);
        present(1, wa, 32'hDEAD_BEEF, pc, 1, lt, lo);
        tick();
        mem_valid_i = 0; mem_load_i = 0;
        for (int i = 0; i < waits; i++) begin
            #1;
            check({tag, "_stallreq"}, 32'(stallreq_o), 32'd1);
            check({tag, "_we_wait"}, 32'(wb_we_o), 32'd0);
            tick();
        end
        dbus_ack_i = 1; dbus_rdata_i = rd;
        #1;
        check({tag, "_stallreq_ack"}, 32'(stallreq_o), 32'd0);
        tick();
        dbus_ack_i = 0;
        check({tag, "_we"}, 32'(wb_we_o), 32'd1);
        check({tag, "_wdata"}, wb_wdata_o, exp);
        check({tag, "_waddr"}, 32'(wb_waddr_o), 32'(wa));
        check({tag, "_pc"}, wb_pc_o, pc);
        check({tag, "_buserr"}, 32'(bus_err_o), 32'd0);
        tick();
        check({tag, "_we_pulse"}, 32'(wb_we_o), 32'd0);
        check({tag, "_idle"}, 32'(stallreq_o), 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        tick(); tick();
        check("rst_we", 32'(wb_we_o), 32'd0);
        check("rst_waddr", 32'(wb_waddr_o), 32'd0);
        check("rst_wdata", wb_wdata_o, 32'd0);
        check("rst_pc", wb_pc_o, 32'd0);
        check("rst_buserr", 32'(bus_err_o), 32'd0);
        check("rst_stallreq", 32'(stallreq_o), 32'd0);
        rst = 1;
        tick();

        write_op("nonload", 5'd5, 32'h0000_1234, 32'hBFC0_0010);
        check("hold_wdata", wb_wdata_o, 32'h0000_1234);

        // Ack lands on the last cycle before timeout: ack must win.
        do_load("lb", 3'd0, 2'd3, 32'h80FF_0000, 3, 5'd7, 32'hBFC0_0020, 32'hFFFF_FF80);
        do_load("lbu", 3'd1, 2'd3, 32'h80FF_0000, 3, 5'd8, 32'hBFC0_0024, 32'h0000_0080);
        do_load("lh", 3'd2, 2'd2, 32'h80FF_0000, 1, 5'd9, 32'hBFC0_0028, 32'hFFFF_80FF);
        do_load("lhu", 3'd3, 2'd1, 32'h1234_8765, 0, 5'd10, 32'hBFC0_002C, 32'h0000_8765);
        do_load("lb1", 3'd0, 2'd1, 32'h0000_7F00, 2, 5'd11, 32'hBFC0_0030, 32'h0000_007F);
        do_load("lw", 3'd4, 2'd3, 32'hCAFE_F00D, 0, 5'd12, 32'hBFC0_0034, 32'hCAFE_F00D);
        do_load("lt7", 3'd7, 2'd2, 32'h8765_4321, 1, 5'd13, 32'hBFC0_0038, 32'h8765_4321);

        // Timeout with stall_i asserted throughout the wait.
        present(1, 5'd14, 32'h0, 32'hBFC0_0040, 1, 3'd4, 2'd0);
        tick();
        mem_valid_i = 0; mem_load_i = 0; stall_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_stallreq", 32'(stallreq_o), 32'd1);
            check("to_buserr_early", 32'(bus_err_o), 32'd0);
            tick();
        end
        stall_i = 0;
        check("to_buserr", 32'(bus_err_o), 32'd1);
        check("to_we", 32'(wb_we_o), 32'd0);
        check("to_idle", 32'(stallreq_o), 32'd0);
        tick();
        check("to_buserr_pulse", 32'(bus_err_o), 32'd0);
        write_op("after_to", 5'd15, 32'h5555_AAAA, 32'hBFC0_0044);

        // Flush wins over a simultaneous ack.
        present(1, 5'd16, 32'h0, 32'hBFC0_0050, 1, 3'd4, 2'd0);
        tick();
        mem_valid_i = 0; mem_load_i = 0;
        tick();
        flush_i = 1; dbus_ack_i = 1; dbus_rdata_i = 32'h1111_2222;
        tick();
        flush_i = 0; dbus_ack_i = 0;
        check("flush_we", 32'(wb_we_o), 32'd0);
        check("flush_wdata_hold", wb_wdata_o, 32'h5555_AAAA);
        #1;
        check("flush_stallreq", 32'(stallreq_o), 32'd0);
        check("flush_buserr", 32'(bus_err_o), 32'd0);

        // Stall bubble then the same instruction again.
        present(1, 5'd17, 32'h0000_AAAA, 32'hBFC0_0060, 0, 0, 0);
        stall_i = 1;
        tick();
        check("stall_we", 32'(wb_we_o), 32'd0);
        stall_i = 0;
        write_op("restall", 5'd17, 32'h0000_AAAA, 32'hBFC0_0060);

        // Flush in IDLE kills the capture.
        present(1, 5'd18, 32'h0000_BBBB, 32'hBFC0_0064, 0, 0, 0);
        flush_i = 1;
        tick();
        flush_i = 0; mem_valid_i = 0;
        check("idle_flush_we", 32'(wb_we_o), 32'd0);

        // wd=0 instruction: no write pulse.
        present(0, 5'd19, 32'h0000_CCCC, 32'hBFC0_0068, 0, 0, 0);
        tick();
        mem_valid_i = 0;
        check("nowd_we", 32'(wb_we_o), 32'd0);

        write_op("waddr0", 5'd0, 32'h0000_0BAD, 32'hBFC0_0070);
        write_op("waddr31", 5'd31, 32'h1357_9BDF, 32'hBFC0_0074);

        // Reset during a pending load abandons it.
        present(1, 5'd20, 32'h0, 32'hBFC0_0080, 1, 3'd4, 2'd0);
        tick();
        mem_valid_i = 0; mem_load_i = 0;
        rst = 0;
        #1;
        check("midrst_stallreq", 32'(stallreq_o), 32'd0);
        check("midrst_wdata", wb_wdata_o, 32'd0);
        check("midrst_pc", wb_pc_o, 32'd0);
        tick();
        rst = 1;
        dbus_ack_i = 1; dbus_rdata_i = 32'hFFFF_FFFF;
        tick();
        dbus_ack_i = 0;
        check("midrst_we", 32'(wb_we_o), 32'd0);
        check("midrst_wdata_after", wb_wdata_o, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
